mem_port_arbiter: RTL

//   Shares the single-port instruction/data memory between the fetch path (control unit IR fetch)
//   and the load/store path. Grants one requester at a time, drives memory address/data/ReadWrite,

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter_lat_cnt.sv | 37 +++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and helpers for the memory port arbiter
//
// Package mem_arb_pkg: FSM state encodings, owner encodings, default memory
// latency and the counter-width helper used by the latency counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  localparam int MEM_LAT_DEFAULT = 3;

  // Width needed to hold MEM_LAT-1; never narrower than one bit so that
  // MEM_LAT=1 (load value 0) still gets a real register.
  function automatic int cnt_width(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory signal bundle for the arbiter
//
// Groups the fetch request, load/store request, read data return and the
// single-port memory bus. The arbiter connects through the slave modport; the
// requesters/memory side (control, datapath, memory model) use master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_done;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_done, ls_done, rdata, mem_addr, mem_wdata, mem_wr, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_done, ls_done, rdata, mem_addr, mem_wdata, mem_wr, busy
  );

endinterface

// File: rtl/mem_port_arbiter_lat_cnt.sv
// rtl/mem_port_arbiter_lat_cnt.sv - loadable down-counter timing the memory read latency
//
// Module mem_arb_lat_cnt
//   clock  in   system clock
//   reset  in   synchronous active-high, clears the count
//   load   in   load MEM_LAT-1 (takes priority over dec)
//   dec    in   decrement, saturating at zero
//   zero   out  count is zero
module mem_arb_lat_cnt
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = cnt_width(MEM_LAT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(MEM_LAT - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the single-port memory between fetch and load/store
//
// Module mem_port_arbiter
//   clock  in   system clock, all state on rising edge
//   reset  in   synchronous active-high
//   bus    slave modport of mem_port_arbiter_if:
//            if_req/if_addr -> if_done          fetch read
//            ls_req/ls_we/ls_addr/ls_wdata -> ls_done   load/store
//            rdata          registered read data, held until the next read completes
//            mem_addr/mem_wdata/mem_wr (registered), mem_rdata   memory bus
//            busy           FSM not idle
// Build option: MEM_ARB_RR_EN selects round-robin on contention; otherwise
// load/store has fixed priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  mem_port_arbiter_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  owner_t            owner;
  logic              if_done_q;
  logic              ls_done_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_wr_q;

  logic              req_any;
  logic              ls_wins;
  logic              grant_ls;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;

`ifdef MEM_ARB_RR_EN
  owner_t            last_owner;

  // On contention grant whoever did not own the port last time.
  assign ls_wins = (last_owner == OWN_IF);
`else
  assign ls_wins = 1'b1;
`endif

  assign req_any  = bus.if_req | bus.ls_req;
  assign grant_ls = bus.ls_req & (~bus.if_req | ls_wins);

  mem_arb_lat_cnt #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_cnt (
    .clock (clock),
    .reset (reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_any) begin
          cnt_load  = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner       <= OWN_IF;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_owner  <= OWN_LS;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            owner       <= grant_ls ? OWN_LS : OWN_IF;
            mem_addr_q  <= grant_ls ? bus.ls_addr : bus.if_addr;
            mem_wdata_q <= grant_ls ? bus.ls_wdata : '0;
            mem_wr_q    <= grant_ls & bus.ls_we;
`ifdef MEM_ARB_RR_EN
            last_owner  <= grant_ls ? OWN_LS : OWN_IF;
`endif
          end else begin
            mem_wr_q <= 1'b0;
          end
        end
        ST_ACCESS: begin
          // mem_wr_q stays set through a store, so it doubles as the
          // "this transfer is a write" flag when the latency expires.
          if (cnt_zero) begin
            if (!mem_wr_q) begin
              rdata_q <= bus.mem_rdata;
            end
            mem_wr_q  <= 1'b0;
            if_done_q <= (owner == OWN_IF);
            ls_done_q <= (owner == OWN_LS);
          end
        end
        ST_DONE: begin
          if_done_q <= 1'b0;
          ls_done_q <= 1'b0;
        end
        default: begin
          if_done_q <= 1'b0;
          ls_done_q <= 1'b0;
          mem_wr_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_done   = if_done_q;
  assign bus.ls_done   = ls_done_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.busy      = (state != ST_IDLE);

endmodule
